// File: rtl/quiz_arbiter.sv
// Contestant lock-in arbiter: synchronizes and debounces the player keys and latches
// the first valid press of an armed round. `QUIZ_FOUL_DETECT_EN adds early-press detection.
module quiz_arbiter #(
  parameter int N_PLAYERS  = 4,
  parameter int DEB_CYCLES = 500000
) (
  input  logic                 CLK,
  input  logic                 RSTn,
  input  logic                 Host_Start,
  input  logic                 Host_Clear,
  input  logic [N_PLAYERS-1:0] Key,
  input  logic                 TimeOver_Block,
  output logic                 Answer,
  output logic [3:0]           Winner,
  output logic [N_PLAYERS-1:0] Player_LED,
  output logic                 Lock_Pulse,
`ifdef QUIZ_FOUL_DETECT_EN
  output logic                 Foul,
  output logic [3:0]           Foul_ID,
`endif
  output logic [2:0]           dbg_state
);

  localparam int CW = $clog2(DEB_CYCLES + 1);
  localparam logic [CW-1:0] DEB_LAST = CW'(DEB_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ARMED,
    S_LOCKED,
    S_EXPIRED
`ifdef QUIZ_FOUL_DETECT_EN
    , S_FOUL
`endif
  } state_t;

  state_t state_q, state_d;

  logic [N_PLAYERS-1:0] key_s1, key_s2, key_deb, press;
  logic                 start_prev, start_rise;
  logic                 press_any;
  logic [3:0]           press_idx;
  logic [N_PLAYERS-1:0] press_1h;

  logic                 answer_d, pulse_d;
  logic [3:0]           winner_d;
  logic [N_PLAYERS-1:0] led_d;
`ifdef QUIZ_FOUL_DETECT_EN
  logic                 foul_d;
  logic [3:0]           foul_id_d;
`endif

  // Keys are active-low, so the synchronizer idles at 1 (released).
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      key_s1 <= '1;
      key_s2 <= '1;
    end else begin
      key_s1 <= Key;
      key_s2 <= key_s1;
    end
  end

  for (genvar i = 0; i < N_PLAYERS; i++) begin : g_deb
    logic [CW-1:0] cnt;
    logic          deb_r;
    logic          prs_r;

    // prs_r is a registered one-cycle strobe on a 1->0 debounced change.
    always_ff @(posedge CLK or negedge RSTn) begin
      if (!RSTn) begin
        cnt   <= '0;
        deb_r <= 1'b1;
        prs_r <= 1'b0;
      end else begin
        prs_r <= 1'b0;
        if (key_s2[i] == deb_r) begin
          cnt <= '0;
        end else if (cnt == DEB_LAST) begin
          cnt   <= '0;
          deb_r <= key_s2[i];
          prs_r <= deb_r;
        end else begin
          cnt <= cnt + 1'b1;
        end
      end
    end

    assign key_deb[i] = deb_r;
    assign press[i]   = prs_r;
  end

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) start_prev <= 1'b1;
    else       start_prev <= Host_Start;
  end

  assign start_rise = Host_Start & ~start_prev;

  // Lowest-index press wins ties.
  always_comb begin
    press_any = |press;
    press_idx = '0;
    for (int i = N_PLAYERS - 1; i >= 0; i--) begin
      if (press[i]) press_idx = 4'(i + 1);
    end
    press_1h = press & (~press + 1'b1);
  end

  always_comb begin
    state_d  = state_q;
    answer_d = Answer;
    winner_d = Winner;
    led_d    = Player_LED;
    pulse_d  = 1'b0;
`ifdef QUIZ_FOUL_DETECT_EN
    foul_d    = Foul;
    foul_id_d = Foul_ID;
`endif
    if (Host_Clear) begin
      state_d  = S_IDLE;
      answer_d = 1'b0;
      winner_d = '0;
      led_d    = '0;
`ifdef QUIZ_FOUL_DETECT_EN
      foul_d    = 1'b0;
      foul_id_d = '0;
`endif
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start_rise) begin
            state_d = S_ARMED;
          end
`ifdef QUIZ_FOUL_DETECT_EN
          else if (press_any) begin
            state_d   = S_FOUL;
            foul_d    = 1'b1;
            foul_id_d = press_idx;
          end
`endif
        end
        S_ARMED: begin
          // Expiry wins over a press seen in the same cycle.
          if (TimeOver_Block) begin
            state_d = S_EXPIRED;
          end else if (press_any) begin
            state_d  = S_LOCKED;
            answer_d = 1'b1;
            winner_d = press_idx;
            led_d    = press_1h;
            pulse_d  = 1'b1;
          end
        end
        S_LOCKED: begin
          if (TimeOver_Block) begin
            state_d  = S_EXPIRED;
            answer_d = 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      state_q    <= S_IDLE;
      Answer     <= 1'b0;
      Winner     <= '0;
      Player_LED <= '0;
      Lock_Pulse <= 1'b0;
`ifdef QUIZ_FOUL_DETECT_EN
      Foul       <= 1'b0;
      Foul_ID    <= '0;
`endif
    end else begin
      state_q    <= state_d;
      Answer     <= answer_d;
      Winner     <= winner_d;
      Player_LED <= led_d;
      Lock_Pulse <= pulse_d;
`ifdef QUIZ_FOUL_DETECT_EN
      Foul       <= foul_d;
      Foul_ID    <= foul_id_d;
`endif
    end
  end

  assign dbg_state = state_q;

endmodule
